// File: rtl/piso_shift_tx.sv
`default_nettype none
// ============================================================================
// Module      : piso_shift_tx
// Description : Parallel-in / serial-out transmitter. Accepts a WIDTH-bit word
//               over a valid/ready handshake and shifts it out one bit at a
//               time on sout, holding each bit for BIT_DIV clocks. Transmit
//               half of the serial link (pairs with a SIPO receiver).
// Ports       : clk        - rising-edge clock
//               rst        - asynchronous, active-high reset
//               in_valid   - source presents a word on in_data
//               in_data    - word to transmit, sampled on handshake only
//               in_ready   - high in IDLE; handshake = in_valid & in_ready
//               sout       - registered serial data (IDLE_LEVEL when idle)
//               sout_valid - registered, high while sout carries a data bit
//               busy       - registered, high while a word is being shifted
//               done       - registered one-cycle pulse after the last bit
// Revision    : 1.0 - initial release
// ============================================================================
module piso_shift_tx #(
    parameter int WIDTH      = 8,
    parameter int BIT_DIV    = 1,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int c_BIT_W = $clog2(WIDTH);
    localparam int c_DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;

    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(WIDTH - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_ONE  = c_BIT_W'(1);
    localparam logic [c_BIT_W-1:0] c_BIT_ZERO = '0;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(BIT_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_ONE  = c_DIV_W'(1);
    localparam logic [c_DIV_W-1:0] c_DIV_ZERO = '0;

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_SHIFT = 1'b1;

    logic [0:0]         r_state;
    logic [WIDTH-1:0]   r_shift;
    logic [c_BIT_W-1:0] r_bit_cnt;
    logic [c_DIV_W-1:0] r_div_cnt;
    logic               r_sout;
    logic               r_sout_valid;
    logic               r_busy;
    logic               r_done;

    logic               w_handshake;
    logic               w_bit_end;
    logic               w_word_end;
    logic [WIDTH-1:0]   w_shift_next;
    logic               w_first_bit;
    logic               w_next_bit;

    // in_ready is decoded straight from state so a source sees it in the
    // done cycle, which is what allows back-to-back words with a 1-cycle gap.
    assign in_ready    = (r_state == c_ST_IDLE);
    assign w_handshake = in_valid & in_ready;

    assign w_bit_end  = (r_div_cnt == c_DIV_LAST);
    assign w_word_end = w_bit_end && (r_bit_cnt == c_BIT_LAST);

    // The shift register always holds the bit currently on sout at its
    // outgoing end; sout is a registered copy, so on load and on each shift
    // the bit that will be at that end next is sampled into r_sout.
    assign w_shift_next = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0}
                                    : {1'b0, r_shift[WIDTH-1:1]};
    assign w_first_bit  = MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
    assign w_next_bit   = MSB_FIRST ? w_shift_next[WIDTH-1] : w_shift_next[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= c_BIT_ZERO;
            r_div_cnt    <= c_DIV_ZERO;
            r_sout       <= IDLE_LEVEL;
            r_sout_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_handshake) begin
                        r_shift      <= in_data;
                        r_bit_cnt    <= c_BIT_ZERO;
                        r_div_cnt    <= c_DIV_ZERO;
                        r_sout       <= w_first_bit;
                        r_sout_valid <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= c_ST_SHIFT;
                    end
                end
                c_ST_SHIFT: begin
                    if (w_word_end) begin
                        r_shift      <= w_shift_next;
                        r_bit_cnt    <= c_BIT_ZERO;
                        r_div_cnt    <= c_DIV_ZERO;
                        r_sout       <= IDLE_LEVEL;
                        r_sout_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_state      <= c_ST_IDLE;
                    end else if (w_bit_end) begin
                        r_shift   <= w_shift_next;
                        r_sout    <= w_next_bit;
                        r_div_cnt <= c_DIV_ZERO;
                        r_bit_cnt <= r_bit_cnt + c_BIT_ONE;
                    end else begin
                        r_div_cnt <= r_div_cnt + c_DIV_ONE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign sout       = r_sout;
    assign sout_valid = r_sout_valid;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_piso_shift_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_shift_tx
// Description : Self-checking bench for piso_shift_tx. Two instances:
//               dut_a (WIDTH=8, BIT_DIV=1, MSB first) and
//               dut_b (WIDTH=8, BIT_DIV=3, LSB first). Expected serial bits
//               are queued when a handshake happens and popped by a monitor
//               for every cycle the DUT flags sout_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_shift_tx;

    localparam int c_BUDGET = 400;

    logic       clk;
    logic       clk_en;
    logic       rst;

    logic       a_valid, a_ready, a_sout, a_sv, a_busy, a_done;
    logic [7:0] a_data;
    logic       b_valid, b_ready, b_sout, b_sv, b_busy, b_done;
    logic [7:0] b_data;

    logic qa[$];
    logic qb[$];

    int total;
    int bad;

    piso_shift_tx #(.WIDTH(8), .BIT_DIV(1), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (a_valid),
        .in_data    (a_data),
        .in_ready   (a_ready),
        .sout       (a_sout),
        .sout_valid (a_sv),
        .busy       (a_busy),
        .done       (a_done)
    );

    piso_shift_tx #(.WIDTH(8), .BIT_DIV(3), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (b_valid),
        .in_data    (b_data),
        .in_ready   (b_ready),
        .sout       (b_sout),
        .sout_valid (b_sv),
        .busy       (b_busy),
        .done       (b_done)
    );

    initial clk = 1'b0;
    always #5 if (clk_en) clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int d); return (d == 0) ? a_ready : b_ready; endfunction
    function automatic logic bsy(input int d); return (d == 0) ? a_busy  : b_busy;  endfunction
    function automatic logic dn (input int d); return (d == 0) ? a_done  : b_done;  endfunction
    function automatic logic sv (input int d); return (d == 0) ? a_sv    : b_sv;    endfunction
    function automatic logic so (input int d); return (d == 0) ? a_sout  : b_sout;  endfunction

    task automatic set_valid(input int d, input logic v);
        if (d == 0) a_valid = v; else b_valid = v;
    endtask

    // dut_a: MSB first, one clock per bit. dut_b: LSB first, three per bit.
    task automatic push_word(input int d, input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            if (d == 0) qa.push_back(w[7-i]);
            else for (int r = 0; r < 3; r++) qb.push_back(w[i]);
        end
    endtask

    // Presents a word and waits (bounded) for in_ready; returns 1 ns after
    // the handshake edge with in_valid still asserted.
    task automatic send(input int d, input logic [7:0] w);
        int t;
        t = 0;
        if (d == 0) a_data = w; else b_data = w;
        set_valid(d, 1'b1);
        while (!rdy(d) && t < c_BUDGET) begin
            @(negedge clk);
            t++;
        end
        chk("handshake_within_budget", {31'd0, t < c_BUDGET}, 32'd1);
        push_word(d, w);
        @(posedge clk);
        #1;
    endtask

    // Checks the busy window of one word and the done cycle that follows.
    // in_valid is dropped at negedge number drop_at (0 = leave it as is).
    task automatic expect_word(input int d, input int drop_at);
        int len;
        len = (d == 0) ? 8 : 24;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            chk("busy_in_word",     {31'd0, bsy(d)}, 32'd1);
            chk("ready_low_in_word",{31'd0, rdy(d)}, 32'd0);
            chk("no_done_in_word",  {31'd0, dn(d)},  32'd0);
            if (k == drop_at) set_valid(d, 1'b0);
        end
        @(negedge clk);
        chk("done_pulse",      {31'd0, dn(d)},  32'd1);
        chk("ready_in_done",   {31'd0, rdy(d)}, 32'd1);
        chk("busy_low_done",   {31'd0, bsy(d)}, 32'd0);
        chk("sv_low_done",     {31'd0, sv(d)},  32'd0);
        chk("idle_level_done", {31'd0, so(d)},  32'd1);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (a_sv) begin
                if (qa.size() == 0) chk("a_unexpected_valid", {31'd0, a_sv}, 32'd0);
                else chk("a_bit", {31'd0, a_sout}, {31'd0, qa.pop_front()});
            end else begin
                chk("a_idle_level", {31'd0, a_sout}, 32'd1);
            end
            if (b_sv) begin
                if (qb.size() == 0) chk("b_unexpected_valid", {31'd0, b_sv}, 32'd0);
                else chk("b_bit", {31'd0, b_sout}, {31'd0, qb.pop_front()});
            end else begin
                chk("b_idle_level", {31'd0, b_sout}, 32'd1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total   = 0;
        bad     = 0;
        clk_en  = 1'b0;
        a_valid = 1'b0; a_data = 8'h00;
        b_valid = 1'b0; b_data = 8'h00;
        rst     = 1'b1;

        // Reset with the clock stopped.
        #3;
        chk("rst_a_sout",  {31'd0, a_sout},  32'd1);
        chk("rst_a_sv",    {31'd0, a_sv},    32'd0);
        chk("rst_a_busy",  {31'd0, a_busy},  32'd0);
        chk("rst_a_done",  {31'd0, a_done},  32'd0);
        chk("rst_a_ready", {31'd0, a_ready}, 32'd1);
        chk("rst_b_sout",  {31'd0, b_sout},  32'd1);
        chk("rst_b_ready", {31'd0, b_ready}, 32'd1);
        clk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);

        // 8'hA5 MSB first, one bit per clock.
        send(0, 8'hA5);
        expect_word(0, 1);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, a_done}, 32'd0);

        // 8'h01 LSB first, three clocks per bit.
        send(1, 8'h01);
        expect_word(1, 1);
        send(1, 8'hB4);
        expect_word(1, 1);

        // Back-to-back: valid held, second handshake lands in the done cycle,
        // in_data changes after each handshake must not reach sout.
        send(0, 8'hFF);
        a_data = 8'h00;
        expect_word(0, 0);
        send(0, 8'h00);
        a_data = 8'h5A;
        expect_word(0, 1);

        // in_valid with a different word while busy: not captured.
        repeat (2) @(negedge clk);
        send(0, 8'h96);
        a_data = 8'h0F;
        expect_word(0, 6);
        repeat (3) begin
            @(negedge clk);
            chk("no_capture_while_busy", {31'd0, a_busy}, 32'd0);
        end

        // Reset in the middle of 8'hC3, then a clean 8'h3C.
        send(0, 8'hC3);
        a_valid = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        chk("mid_word_bit3", {31'd0, a_sout}, 32'd0);
        rst = 1'b1;
        qa.delete();
        #1;
        chk("midrst_sout",  {31'd0, a_sout},  32'd1);
        chk("midrst_sv",    {31'd0, a_sv},    32'd0);
        chk("midrst_busy",  {31'd0, a_busy},  32'd0);
        chk("midrst_ready", {31'd0, a_ready}, 32'd1);
        repeat (2) begin
            @(negedge clk);
            chk("midrst_no_done", {31'd0, a_done}, 32'd0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_done", {31'd0, a_done}, 32'd0);
        end
        send(0, 8'h3C);
        expect_word(0, 1);

        repeat (4) @(negedge clk);
        chk("a_queue_drained", qa.size(), 32'd0);
        chk("b_queue_drained", qb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
